// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin pick function for the Wishbone arbiter.
// The pick function has a fixed maximum width; callers cast to their own width.
package wb_arb_pkg;

  localparam int unsigned MaxMasters = 8;
  localparam int unsigned PtrW       = 3;

  typedef enum logic {
    IDLE,
    OWNED
  } wb_arb_state_e;

  // One-hot of the first set bit of req at or after ptr, wrapping modulo n.
  function automatic logic [MaxMasters-1:0] rr_pick(input logic [MaxMasters-1:0] req,
                                                    input logic [PtrW-1:0]       ptr,
                                                    input int unsigned           n);
    logic [MaxMasters-1:0] pick;
    logic                  found;
    logic [PtrW-1:0]       idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxMasters; k++) begin
      idx = PtrW'((32'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle with master and slave views.
interface wb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic [DW/8-1:0] SEL;
  logic            WE;
  logic            CYC;
  logic            STB;
  logic            ACK;

  modport master (output ADR, DAT_W, SEL, WE, CYC, STB, input DAT_R, ACK);
  modport slave  (input ADR, DAT_W, SEL, WE, CYC, STB, output DAT_R, ACK);
endinterface

// File: rtl/rr_prio_select.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_prio_select
  import wb_arb_pkg::*;
#(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    sel,
  output logic            valid
);

  assign sel   = N'(rr_pick(MaxMasters'(req), PtrW'(ptr), N));
  assign valid = |req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: a master owns the shared slave from grant until it
// drops CYC; priority rotates past the last owner on every release.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS        = 2,
  parameter int unsigned WB_ADDRESS_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  wb_if.slave                  m [N_MASTERS],
  wb_if.master                 s,
  output logic [N_MASTERS-1:0] gnt
);

  localparam int unsigned IdxW = $clog2(N_MASTERS);
  localparam int unsigned SelW = WB_DATA_WIDTH / 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_MASTERS - 1);

  logic [N_MASTERS-1:0]        req, m_stb, m_we;
  logic [WB_ADDRESS_WIDTH-1:0] m_adr   [N_MASTERS];
  logic [WB_DATA_WIDTH-1:0]    m_dat_w [N_MASTERS];
  logic [SelW-1:0]             m_sel   [N_MASTERS];

  wb_arb_state_e        state_q, state_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [IdxW-1:0]      prio_q, prio_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;

  logic [N_MASTERS-1:0] pick_sel;
  logic                 pick_valid;
  logic [IdxW-1:0]      pick_idx;
  logic                 owned;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_master
    assign req[i]     = m[i].CYC;
    assign m_stb[i]   = m[i].STB;
    assign m_we[i]    = m[i].WE;
    assign m_adr[i]   = m[i].ADR;
    assign m_dat_w[i] = m[i].DAT_W;
    assign m_sel[i]   = m[i].SEL;
    // gnt_q is zero outside OWNED, so non-owners and the idle state never see ACK.
    assign m[i].ACK   = gnt_q[i] & s.ACK;
    assign m[i].DAT_R = s.DAT_R;
  end

  rr_prio_select #(
    .N(N_MASTERS)
  ) u_prio_select (
    .req  (req),
    .ptr  (prio_q),
    .sel  (pick_sel),
    .valid(pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (pick_sel[i]) pick_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          gnt_d   = pick_sel;
          owner_d = pick_idx;
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          prio_d  = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

  // Slave path is purely combinational from the registered owner.
  assign owned   = (state_q == OWNED);
  assign s.CYC   = owned & req[owner_q];
  assign s.STB   = owned & m_stb[owner_q];
  assign s.WE    = owned & m_we[owner_q];
  assign s.ADR   = owned ? m_adr[owner_q]   : '0;
  assign s.DAT_W = owned ? m_dat_w[owner_q] : '0;
  assign s.SEL   = owned ? m_sel[owner_q]   : '0;
  assign gnt     = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench for wb_rr_arbiter against an ownership/rotation reference model.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0]  cyc, stb, we;
  logic [AW-1:0] adr   [N];
  logic [DW-1:0] dat_w [N];
  logic [SW-1:0] sel   [N];
  logic [N-1:0]  ack;
  logic [DW-1:0] m_dat_r [N];
  logic          s_ack;
  logic [DW-1:0] s_dat_r;
  logic [N-1:0]  gnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current owner (-1 = nobody), rotation pointer, cycles held.
  int owner      = -1;
  int ptr        = 0;
  int own_cycles = 0;

  wb_if #(.AW(AW), .DW(DW)) m_if [N] ();
  wb_if #(.AW(AW), .DW(DW)) s_if ();

  for (genvar i = 0; i < N; i++) begin : g_m
    assign m_if[i].CYC   = cyc[i];
    assign m_if[i].STB   = stb[i];
    assign m_if[i].WE    = we[i];
    assign m_if[i].ADR   = adr[i];
    assign m_if[i].DAT_W = dat_w[i];
    assign m_if[i].SEL   = sel[i];
    assign ack[i]        = m_if[i].ACK;
    assign m_dat_r[i]    = m_if[i].DAT_R;
  end
  assign s_if.ACK   = s_ack;
  assign s_if.DAT_R = s_dat_r;

  wb_rr_arbiter #(
    .N_MASTERS       (N),
    .WB_ADDRESS_WIDTH(AW),
    .WB_DATA_WIDTH   (DW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .m   (m_if),
    .s   (s_if),
    .gnt (gnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, ea;
    eg = '0;
    ea = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ea[owner] = s_ack;
    end
    check_eq("gnt", 64'(gnt), 64'(eg));
    check_eq("ack", 64'(ack), 64'(ea));
    if (owner < 0) begin
      check_eq("idle_cyc", 64'(s_if.CYC), 64'(0));
      check_eq("idle_stb", 64'(s_if.STB), 64'(0));
      check_eq("idle_we", 64'(s_if.WE), 64'(0));
      check_eq("idle_adr", 64'(s_if.ADR), 64'(0));
      check_eq("idle_sel", 64'(s_if.SEL), 64'(0));
    end else begin
      check_eq("s_cyc", 64'(s_if.CYC), 64'(cyc[owner]));
      check_eq("s_stb", 64'(s_if.STB), 64'(stb[owner]));
      check_eq("s_we", 64'(s_if.WE), 64'(we[owner]));
      check_eq("s_adr", 64'(s_if.ADR), 64'(adr[owner]));
      check_eq("s_dat_w", 64'(s_if.DAT_W), 64'(dat_w[owner]));
      check_eq("s_sel", 64'(s_if.SEL), 64'(sel[owner]));
    end
    for (int i = 0; i < N; i++) check_eq("dat_r_bcast", 64'(m_dat_r[i]), 64'(s_dat_r));
  endtask

  // Mode 0: random masters; 1: everyone requests, owner leaves after 3 cycles; 2: quiet.
  task automatic drive(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin
          if (!cyc[i]) cyc[i] = ($urandom_range(99) < 30);
          else         cyc[i] = ($urandom_range(99) >= 20);
        end
        1:       cyc[i] = !(i == owner && own_cycles >= 2);
        default: cyc[i] = 1'b0;
      endcase
      stb[i]   = (mode == 2) ? 1'b0 : 1'($urandom_range(1));
      we[i]    = 1'($urandom_range(1));
      adr[i]   = $urandom;
      dat_w[i] = $urandom;
      sel[i]   = SW'($urandom);
    end
    s_ack   = 1'($urandom_range(1));
    s_dat_r = $urandom;
  endtask

  task automatic model_edge();
    int idx;
    if (!rstn) begin
      owner = -1;
      ptr   = 0;
      return;
    end
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (cyc[idx]) begin
          owner      = idx;
          own_cycles = 0;
          break;
        end
      end
    end else if (!cyc[owner]) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end else begin
      own_cycles++;
    end
  endtask

  task automatic step(input int mode);
    @(negedge clk);
    drive(mode);
    #1 check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic reset_while_owned();
    int waited = 0;
    while (owner < 0 && waited < 300) begin
      step(0);
      waited++;
    end
    if (owner < 0) begin
      check_eq("own_wait_timeout", 64'(0), 64'(1));
      return;
    end
    @(negedge clk);
    #1 check_eq("pre_rst_cyc", 64'(s_if.CYC), 64'(1));
    rstn = 1'b0;
    #1;
    check_eq("async_rst_cyc", 64'(s_if.CYC), 64'(0));
    check_eq("async_rst_gnt", 64'(gnt), 64'(0));
    check_eq("async_rst_ack", 64'(ack), 64'(0));
    owner = -1;
    ptr   = 0;
    step(2);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b0;
    cyc     = '0;
    stb     = '0;
    we      = '0;
    s_ack   = 1'b0;
    s_dat_r = '0;
    for (int i = 0; i < N; i++) begin
      adr[i]   = '0;
      dat_w[i] = '0;
      sel[i]   = '0;
    end
    repeat (3) step(2);
    @(negedge clk);
    rstn = 1'b1;

    repeat (500) step(0);
    repeat (80) step(1);
    repeat (3) begin
      reset_while_owned();
      repeat (50) step(0);
    end
    repeat (80) step(1);
    repeat (500) step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter sharing one Wishbone slave port (typically a memory or peripheral fabric behind `axi4_wb_bridge` instances) between N Wishbone masters. Ownership is granted per bus cycle: a master keeps the slave from grant until it deasserts CYC, so multi-beat bridge writes are never interleaved. Priority rotates after each release, so no requester starves.

## Interface
Parameters:
- `N_MASTERS`, 2: number of requesting masters, legal range 2..8.
- `WB_ADDRESS_WIDTH`, 32: address width of all ports.
- `WB_DATA_WIDTH`, 32: data width of all ports; SEL width is `WB_DATA_WIDTH/8`.

Ports:
- `clk`  input  1  single clock for all logic.
- `rstn`  input  1  reset; **asynchronous, active-low**.
- `m[N_MASTERS]`  `wb_if.slave`  -  requesting masters.
- `s`  `wb_if.master`  -  shared slave port.
- `gnt`  output  N_MASTERS  one-hot current owner; all zero when idle.

## Operation
- States: IDLE, OWNED.
- Request from master i = `m[i].CYC`. STB is not required to request.
- IDLE: if any request, select the first requester at or after `prio_ptr`, scanning upward mod N_MASTERS. Register the selection into `gnt` and `owner` and go to OWNED. Otherwise stay in IDLE.
- OWNED:
  - `s.ADR/DAT_W/SEL/WE/CYC/STB` = owner's signals.
  - `m[owner].ACK` = `s.ACK`.
  - All other masters see ACK = 0.
  - `s.DAT_R` is broadcast to all masters.
- OWNED exit: when `m[owner].CYC` == 0, go to IDLE, clear `gnt`, set `prio_ptr` = (owner+1) mod N_MASTERS.
- Requests from non-owners during OWNED are held pending, not latched. A master that drops CYC before it is granted simply loses its request.
- IDLE: `s.CYC` = `s.STB` = `s.WE` = 0, `s.SEL` = 0, `s.ADR` = 0, and every ACK = 0.
- Reset values: state IDLE, `prio_ptr` 0, `gnt` 0, all slave strobes 0, all ACKs 0.
- Reset mid-transaction: ownership is dropped immediately and asynchronously. The slave sees CYC fall with no completion; this is not guarded.

## Timing
- Grant latency: a request sampled in IDLE at edge k gives OWNED and `s.CYC` forwarded after edge k. Earliest `s.STB` is 1 cycle after the master raises CYC+STB.
- The slave path is combinational from owner to `s.*` (no added pipeline). ACK returns combinationally to the owner in the same cycle.
- Release: owner drops CYC at edge r, so IDLE begins after r. The next grant is registered at r+1. Exactly one dead cycle separates owners.
- A single requester re-requesting immediately after release regains the grant after the dead cycle. `prio_ptr` still rotates.
- Simultaneous requests in IDLE: the lowest index at or after `prio_ptr` wins. Wrap from N_MASTERS-1 to 0.
- No timeout: an owner holding CYC indefinitely blocks all others. This is a documented system constraint.

## Structure
- Shared package `wb_arb_pkg`:
  - state enum `wb_arb_state_e` {IDLE, OWNED}.
  - function `rr_pick(req, ptr)`, returning a one-hot vector.
- Sub-module `rr_prio_select` (combinational round-robin picker, parameter N): inputs `req[N]` and `ptr`, outputs one-hot `sel` and `valid`. It is reusable by future AXI arbiters.
- Index width: `$clog2(N_MASTERS)`.
- Owner multiplexing is a generate loop over interface array members.

## Test plan
- Reset and idle: `rstn` low for 3 cycles, no requests -> `gnt`=0, `s.CYC`=0, all ACK=0. Pulse `rstn` low while OWNED -> `s.CYC` falls without waiting for an edge.
- Single master: m[1] issues a read of ADR=0x100, slave ACKs with DAT_R=0xDEADBEEF -> `gnt`=2'b10 one cycle after CYC, m[1] gets the data, m[0].ACK stays 0.
- Contention rotation (N=3): all masters hold CYC continuously and each does one transfer then drops -> grant order 0,1,2,0 with one idle cycle between owners.
- Burst lock: m[0] holds CYC through 4 write beats (0x0..0xC) while m[1] requests -> slave sees 4 consecutive m[0] writes, and m[1] is granted only after m[0] drops CYC.
- Wrap and priority: `prio_ptr`=2 (N=3), m[0] and m[1] request together -> m[0] granted, then `prio_ptr`=1.
- Withdrawn request: m[1] raises CYC during m[0] ownership and drops it before release -> m[1] is never granted and IDLE persists after m[0] releases.
